// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared types and helpers for the instruction-fetch front end.
//   ILEN          - instruction / address width
//   FETCH_ENTRY_W - width of one prefetch FIFO entry {pc, instr}
//   PC_STEP       - byte distance between sequential instruction words
//   align_pc()    - clears the byte-offset bits of a PC
package rv_fetch_pkg;

    localparam int ILEN          = 32;
    localparam int FETCH_ENTRY_W = 64;
    localparam logic [ILEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ILEN-1:0] align_pc(input logic [ILEN-1:0] pc);
        return {pc[ILEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, occupancy count and registered head.
//   clk_i, rst_n_i - clock, synchronous active-low reset (storage cleared too)
//   flush_i        - drop all entries (wins over push/pop)
//   push_i, data_i - write an entry
//   pop_i          - consume the head; ignored when empty
//   valid_o        - head valid
//   data_o         - head entry, read straight from the storage registers
//   count_o        - number of valid entries
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int WIDTH = FETCH_ENTRY_W,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_eff_s;

    // A pop on an empty FIFO is a no-op, so push+pop on empty is simply a push.
    assign pop_eff_s = pop_i && (count_r != '0);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_i) begin
                mem_r[wr_ptr_r] <= data_i;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_eff_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_i, pop_eff_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign valid_o = (count_r != '0);
    assign data_o  = mem_r[rd_ptr_r];
    assign count_o = count_r;

    fetch_fifo_checker #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_checker (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .push_i  (push_i),
        .pop_i   (pop_eff_s),
        .count_i (count_r)
    );

endmodule

// File: rtl/fetch_fifo_checker.sv
// fetch_fifo_checker: protocol assertions for fetch_fifo.
//   clk_i, rst_n_i        - clock, synchronous active-low reset
//   flush_i, push_i       - FIFO control as seen by the FIFO
//   pop_i                 - effective pop (head was valid and consumed)
//   count_i               - current occupancy
module fetch_fifo_checker #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk_i,
    input logic          rst_n_i,
    input logic          flush_i,
    input logic          push_i,
    input logic          pop_i,
    input logic [CW-1:0] count_i
);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    // A push into a full FIFO without a same-cycle pop would overwrite the head.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(push_i && !pop_i && !flush_i && (count_i == FULL_C)));

    // Occupancy can never exceed the number of entries.
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        count_i <= FULL_C);

endmodule

// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: instruction-fetch front end with multiple outstanding requests.
//   clk_i, rst_n_i          - clock, synchronous active-low reset
//   i_req_o, i_addr_o       - fetch request and word-aligned address
//   i_gnt_i                 - memory accepted the request this cycle
//   i_rvalid_i, i_rdata_i   - in-order response
//   redirect_i/_pc_i        - taken branch/jump: flush and refetch from new PC
//   instr_valid_o/_o/_pc_o  - prefetch FIFO head towards decode
//   instr_ready_i           - decode consumes the head on valid & ready
module rv_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        i_req_o,
    output logic [31:0] i_addr_o,
    input  logic        i_gnt_i,
    input  logic        i_rvalid_i,
    input  logic [31:0] i_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1'b1);

    logic [ILEN-1:0] fpc_r, fpc_next_s;
    logic [ILEN-1:0] rsp_pc_r, rsp_pc_next_s;
    logic [CW-1:0]   outstanding_r, outstanding_next_s;
    logic [CW-1:0]   discard_r, discard_next_s;
    logic [CW-1:0]   fifo_count_s;
    logic [CW:0]     credit_used_s;
    logic            req_s, gnt_s, drop_s, push_s, pop_s, head_valid_s;
    fetch_entry_t    push_entry_s, head_entry_s;

    // In-flight requests plus buffered entries never exceed the FIFO size,
    // which is what makes a push into a full FIFO impossible.
    assign credit_used_s = {1'b0, outstanding_r} + {1'b0, fifo_count_s};
    assign req_s  = rst_n_i && !redirect_i && (credit_used_s < CREDIT_LIMIT);
    assign gnt_s  = req_s && i_gnt_i;
    // A response arriving with a redirect is stale whatever the discard count.
    assign drop_s = i_rvalid_i && (redirect_i || (discard_r != '0));
    assign push_s = i_rvalid_i && !drop_s;
    assign pop_s  = head_valid_s && instr_ready_i;
    assign push_entry_s = '{pc: rsp_pc_r, instr: i_rdata_i};

    // Next-state for fetch PC, response PC, outstanding and discard counters.
    always_comb begin
        fpc_next_s         = fpc_r;
        rsp_pc_next_s      = rsp_pc_r;
        outstanding_next_s = outstanding_r;
        discard_next_s     = discard_r;
        case ({gnt_s, i_rvalid_i})
            2'b10:   outstanding_next_s = outstanding_r + CNT_ONE;
            2'b01:   outstanding_next_s = outstanding_r - CNT_ONE;
            default: outstanding_next_s = outstanding_r;
        endcase
        if (redirect_i) begin
            fpc_next_s    = align_pc(redirect_pc_i);
            rsp_pc_next_s = align_pc(redirect_pc_i);
            // No grant is possible here, so everything still in flight is stale.
            if (i_rvalid_i) begin
                discard_next_s = outstanding_r - CNT_ONE;
            end else begin
                discard_next_s = outstanding_r;
            end
        end else begin
            if (gnt_s) begin
                fpc_next_s = fpc_r + PC_STEP;
            end else begin
                fpc_next_s = fpc_r;
            end
            if (push_s) begin
                rsp_pc_next_s = rsp_pc_r + PC_STEP;
            end else begin
                rsp_pc_next_s = rsp_pc_r;
            end
            if (drop_s) begin
                discard_next_s = discard_r - CNT_ONE;
            end else begin
                discard_next_s = discard_r;
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fpc_r         <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= '0;
            discard_r     <= '0;
        end else begin
            fpc_r         <= fpc_next_s;
            rsp_pc_r      <= rsp_pc_next_s;
            outstanding_r <= outstanding_next_s;
            discard_r     <= discard_next_s;
        end
    end

    fetch_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (redirect_i),
        .push_i  (push_s),
        .data_i  (push_entry_s),
        .pop_i   (pop_s),
        .valid_o (head_valid_s),
        .data_o  (head_entry_s),
        .count_o (fifo_count_s)
    );

    assign i_req_o       = req_s;
    assign i_addr_o      = fpc_r;
    assign instr_valid_o = head_valid_s;
    assign instr_o       = head_entry_s.instr;
    assign instr_pc_o    = head_entry_s.pc;

endmodule

// File: tb/tb_rv_fetch_unit.sv
// tb_rv_fetch_unit: self-checking bench for rv_fetch_unit.
// The memory model returns a word derived from the granted address; the
// reference expects the delivered stream to be consecutive PCs starting at the
// last redirect target (or reset PC), each carrying the word of its address.
module tb_rv_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, gnt, rvalid, redirect, ready;
    logic [31:0] rdata, redirect_pc;
    logic        a_req, a_valid, b_req, b_valid;
    logic [31:0] a_addr, a_instr, a_pc, b_addr, b_instr, b_pc;

    always #5 clk = ~clk;

    rv_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .i_req_o(a_req), .i_addr_o(a_addr),
        .i_gnt_i(gnt), .i_rvalid_i(rvalid), .i_rdata_i(rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .instr_valid_o(a_valid), .instr_o(a_instr), .instr_pc_o(a_pc),
        .instr_ready_i(ready));

    rv_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_hi (
        .clk_i(clk), .rst_n_i(rst_n), .i_req_o(b_req), .i_addr_o(b_addr),
        .i_gnt_i(gnt), .i_rvalid_i(rvalid), .i_rdata_i(rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .instr_valid_o(b_valid), .instr_o(b_instr), .instr_pc_o(b_pc),
        .instr_ready_i(ready));

    typedef struct { logic [31:0] addr; int due; } rsp_t;
    rsp_t        mq[$];
    int          tests_run = 0, tests_failed = 0;
    int          cycle = 0, last_due = 0, mem_lat = 1, gnt_pct = 100;
    int          n_deliv = 0, credit_viol = 0;
    logic [31:0] exp_fetch = 32'h0, exp_pc = 32'h0;
    logic        sa_req, sa_valid, sa_rvalid, s_gnt, s_hs, sb_req, sb_valid;
    logic [31:0] sa_addr, sa_pc, sa_instr, sb_addr, sb_pc, sb_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_A5A5;
    endfunction

    // One clock cycle: drive memory, sample at negedge, update reference model.
    task automatic step();
        int d;
        if (mq.size() > 0 && mq[0].due <= cycle) begin
            rvalid = 1'b1;
            rdata  = mem_word(mq[0].addr);
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
        end
        gnt = (int'($urandom_range(99)) < gnt_pct);
        @(negedge clk);
        sa_req = a_req; sa_addr = a_addr; sa_valid = a_valid; sa_pc = a_pc; sa_instr = a_instr;
        sb_req = b_req; sb_addr = b_addr; sb_valid = b_valid; sb_pc = b_pc; sb_instr = b_instr;
        sa_rvalid = rvalid;
        s_gnt = 1'b0;
        s_hs  = 1'b0;
        if (!rst_n) begin
            mq.delete();
            last_due  = 0;
            exp_fetch = 32'h0;
            exp_pc    = 32'h0;
        end else begin
            s_gnt = a_req && gnt;
            s_hs  = a_valid && ready;
            tests_run++;
            if (redirect && a_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL req_in_redirect: got %b expected 0", a_req);
            end
            if (s_gnt) begin
                tests_run++;
                if (a_addr !== exp_fetch) begin
                    tests_failed++;
                    $display("FAIL grant_addr: got %h expected %h", a_addr, exp_fetch);
                end
                exp_fetch = exp_fetch + 32'd4;
                d = cycle + mem_lat;
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mq.push_back('{addr: a_addr, due: d});
            end
            if (rvalid) void'(mq.pop_front());
            if (mq.size() > DEPTH) credit_viol++;
            if (s_hs) begin
                tests_run++;
                if (a_pc !== exp_pc || a_instr !== mem_word(exp_pc)) begin
                    tests_failed++;
                    $display("FAIL deliver: got pc %h instr %h expected pc %h instr %h",
                             a_pc, a_instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                n_deliv++;
            end
            if (redirect) begin
                exp_fetch = {redirect_pc[31:2], 2'b00};
                exp_pc    = {redirect_pc[31:2], 2'b00};
            end
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ready = 1'b1; gnt_pct = 100; mem_lat = 1;
        do_reset();
        tests_run++;
        if (sa_req !== 1'b0 || sa_valid !== 1'b0 || sa_instr !== 32'h0 || sa_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got req %b valid %b instr %h pc %h expected all 0",
                     sa_req, sa_valid, sa_instr, sa_pc);
        end
        tests_run++;
        if (sa_addr !== 32'h0 || sb_addr !== 32'hFFFF_FFF8) begin
            tests_failed++;
            $display("FAIL reset_pc: got %h/%h expected 00000000/fffffff8", sa_addr, sb_addr);
        end
    endtask

    task automatic test_stream();
        int gaps = 0;
        logic [31:0] addrs [3];
        logic        valids [3];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            addrs[i]  = sa_req ? sa_addr : 32'hDEAD_BEEF;
            valids[i] = sa_valid;
        end
        tests_run++;
        if (addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8) begin
            tests_failed++;
            $display("FAIL stream_addr: got %h %h %h expected 0 4 8", addrs[0], addrs[1], addrs[2]);
        end
        tests_run++;
        if (valids[0] !== 1'b0 || valids[1] !== 1'b0 || valids[2] !== 1'b1 || sa_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL first_valid: got %b%b%b pc %h expected 001 pc 0",
                     valids[0], valids[1], valids[2], sa_pc);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (sa_valid !== 1'b1) gaps++;
        end
        tests_run++;
        if (gaps !== 0) begin
            tests_failed++;
            $display("FAIL throughput: got %0d bubbles expected 0", gaps);
        end
    endtask

    task automatic test_backpressure();
        int grants = 0, head_bad = 0;
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_gnt) grants++;
            if (sa_valid && sa_pc !== 32'h0) head_bad++;
        end
        tests_run++;
        if (grants !== DEPTH || sa_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_grants: got %0d grants req %b expected 4 req 0", grants, sa_req);
        end
        tests_run++;
        if (sa_valid !== 1'b1 || sa_pc !== 32'h0 || head_bad !== 0) begin
            tests_failed++;
            $display("FAIL bp_head: got valid %b pc %h bad %0d expected 1 0 0", sa_valid, sa_pc, head_bad);
        end
        ready = 1'b1;
        step();
        step();
        tests_run++;
        if (sa_req !== 1'b1 || sa_addr !== 32'h10) begin
            tests_failed++;
            $display("FAIL bp_resume: got req %b addr %h expected 1 00000010", sa_req, sa_addr);
        end
        for (int i = 0; i < 5; i++) step();
    endtask

    task automatic test_redirect_stale();
        int early = 0, stale = 0;
        do_reset();
        mem_lat = 3;
        step(); step(); step();
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (sa_valid !== 1'b0) early++;
        end
        step();
        tests_run++;
        if (early !== 0 || sa_valid !== 1'b1 || sa_pc !== 32'h100) begin
            tests_failed++;
            $display("FAIL stale_drop: got early %0d valid %b pc %h expected 0 1 00000100", early, sa_valid, sa_pc);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            if (sa_valid && sa_pc >= 32'h4 && sa_pc <= 32'hC) stale++;
        end
        tests_run++;
        if (stale !== 0) begin
            tests_failed++;
            $display("FAIL stale_pc: got %0d stale entries expected 0", stale);
        end
    endtask

    task automatic test_redirect_same_cycle();
        logic [31:0] hs_pc;
        int repeats = 0;
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 6; i++) step();
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        hs_pc = sa_pc;
        tests_run++;
        if (s_hs !== 1'b1 || sa_rvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL sc_setup: got hs %b rvalid %b expected 1 1", s_hs, sa_rvalid);
        end
        step();
        tests_run++;
        if (sa_valid !== 1'b0 || sa_req !== 1'b1 || sa_addr !== 32'h200) begin
            tests_failed++;
            $display("FAIL sc_refetch: got valid %b req %b addr %h expected 0 1 00000200", sa_valid, sa_req, sa_addr);
        end
        step();
        step();
        tests_run++;
        if (sa_valid !== 1'b1 || sa_pc !== 32'h200) begin
            tests_failed++;
            $display("FAIL sc_next: got valid %b pc %h expected 1 00000200", sa_valid, sa_pc);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (sa_valid && sa_pc === hs_pc) repeats++;
        end
        tests_run++;
        if (repeats !== 0) begin
            tests_failed++;
            $display("FAIL sc_once: got %0d repeats of %h expected 0", repeats, hs_pc);
        end
    endtask

    task automatic test_back_to_back();
        int early = 0, budget = 0;
        do_reset();
        mem_lat = 3;
        step(); step();
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        tests_run++;
        if (sa_rvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_setup: got rvalid %b expected 1", sa_rvalid);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0 && (s_gnt !== 1'b1 || sa_addr !== 32'h80)) early++;
            if (sa_valid !== 1'b0) early++;
        end
        step();
        tests_run++;
        if (early !== 0 || sa_valid !== 1'b1 || sa_pc !== 32'h80) begin
            tests_failed++;
            $display("FAIL b2b_target: got errs %0d valid %b pc %h expected 0 1 00000080", early, sa_valid, sa_pc);
        end
        for (int i = 0; i < 5; i++) step();
        redirect = 1'b1; redirect_pc = 32'h103;
        step();
        redirect = 1'b0;
        s_gnt = 1'b0;
        while (!s_gnt && budget < 20) begin
            step();
            budget++;
        end
        tests_run++;
        if (!s_gnt || sa_addr !== 32'h100) begin
            tests_failed++;
            $display("FAIL align_fetch: got gnt %b addr %h expected 1 00000100", s_gnt, sa_addr);
        end
        budget = 0;
        while (!sa_valid && budget < 30) begin
            step();
            budget++;
        end
        tests_run++;
        if (sa_valid !== 1'b1 || sa_pc !== 32'h100) begin
            tests_failed++;
            $display("FAIL align_deliver: got valid %b pc %h expected 1 00000100", sa_valid, sa_pc);
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] addrs [3];
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            addrs[i] = sb_req ? sb_addr : 32'hDEAD_BEEF;
        end
        tests_run++;
        if (addrs[0] !== 32'hFFFF_FFF8 || addrs[1] !== 32'hFFFF_FFFC || addrs[2] !== 32'h0) begin
            tests_failed++;
            $display("FAIL wrap_addr: got %h %h %h expected fffffff8 fffffffc 00000000", addrs[0], addrs[1], addrs[2]);
        end
        tests_run++;
        if (sb_valid !== 1'b1 || sb_pc !== 32'hFFFF_FFF8) begin
            tests_failed++;
            $display("FAIL wrap_first: got valid %b pc %h expected 1 fffffff8", sb_valid, sb_pc);
        end
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        step();
        step();
        tests_run++;
        if (sa_req !== 1'b0 || sa_valid !== 1'b0 || sa_instr !== 32'h0 || sa_pc !== 32'h0 ||
            sb_req !== 1'b0 || sb_valid !== 1'b0 || sb_instr !== 32'h0 || sb_pc !== 32'h0) begin
            tests_failed++;
            $display("FAIL midburst_reset: got a %b%b %h %h b %b%b %h %h expected all 0",
                     sa_req, sa_valid, sa_instr, sa_pc, sb_req, sb_valid, sb_instr, sb_pc);
        end
        tests_run++;
        if (sb_addr !== 32'hFFFF_FFF8) begin
            tests_failed++;
            $display("FAIL midburst_pc: got %h expected fffffff8", sb_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int start, target, budget = 0;
        do_reset();
        credit_viol = 0;
        start = n_deliv;
        gnt_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            mem_lat     = $urandom_range(1, 4);
            ready       = ($urandom_range(3) != 0);
            redirect    = ($urandom_range(99) < 3);
            redirect_pc = $urandom;
            step();
        end
        redirect = 1'b0;
        tests_run++;
        if (credit_viol !== 0) begin
            tests_failed++;
            $display("FAIL credit_bound: got %0d violations expected 0", credit_viol);
        end
        tests_run++;
        if (n_deliv - start < 100) begin
            tests_failed++;
            $display("FAIL random_progress: got %0d deliveries expected at least 100", n_deliv - start);
        end
        ready = 1'b1; gnt_pct = 100; mem_lat = 1;
        target = n_deliv + 8;
        while (n_deliv < target && budget < 200) begin
            step();
            budget++;
        end
        tests_run++;
        if (n_deliv < target) begin
            tests_failed++;
            $display("FAIL drain_timeout: got %0d deliveries expected %0d", n_deliv, target);
        end
    endtask

    initial begin
        rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stale();
        test_redirect_same_cycle();
        test_back_to_back();
        test_wrap_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
